if_fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the 5-stage LoongArch32 pipeline; feeds the ID stage through the if_ready/allow_in handshake.
- Generates the next PC (sequential +4 or ID redirect), drives the instruction SRAM and holds the fetched instruction while ID stalls.
- Consumes ID's flush/newpc redirect and kills the wrong-path instruction.

---
 rtl/cpu_defs.sv | 27 ++
 rtl/if_fetch_stage_skid.sv | 40 ++++
 rtl/if_fetch_stage.sv | 101 ++++++++++
 tb/tb_if_fetch_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared constants and types for the LoongArch32 5-stage pipeline.
//   RESET_PC    : first instruction address fetched after reset
//   PC_W        : PC / address width
//   INST_NOP    : canonical NOP encoding (andi r0, r0, 0)
//   IF_ID_BUS_W : width of the packed IF->ID bus {pc, inst}
package cpu_defs;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INST_W      = 32;
  localparam logic [31:0] RESET_PC    = 32'h1c00_0000;
  localparam logic [31:0] INST_NOP    = 32'h0340_0000;
  localparam int unsigned IF_ID_BUS_W = PC_W + INST_W;

  // IF->ID bus, pc in the upper half.
  typedef logic [IF_ID_BUS_W-1:0] if_id_bus_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

  function automatic if_id_bus_t pack_if_id(input logic [PC_W-1:0] pc,
                                            input logic [INST_W-1:0] inst);
    return {pc, inst};
  endfunction

endpackage

// File: rtl/if_fetch_stage_skid.sv
// Instruction hold buffer for the IF stage.
// The instruction SRAM only presents read data for one cycle after the read
// is issued. When ID stalls, the first stall cycle captures that data so the
// instruction shown to ID stays stable however long the stall lasts.
//   clk, reset : clock, synchronous active-high reset
//   i_issue    : a new fetch is issued this cycle (drops any buffered word)
//   i_stall    : IF holds a valid instruction that ID is not taking
//   i_rdata    : instruction SRAM read data
//   o_inst     : instruction presented to ID
module if_fetch_stage_skid
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_issue,
  input  logic              i_stall,
  input  logic [INST_W-1:0] i_rdata,
  output logic [INST_W-1:0] o_inst
);

  logic [INST_W-1:0] r_inst_buf;
  logic              r_buf_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_buf  <= '0;
      r_buf_valid <= 1'b0;
    end else if (i_issue) begin
      // The buffered word belongs to the instruction being replaced.
      r_buf_valid <= 1'b0;
    end else if (i_stall && !r_buf_valid) begin
      // rdata is only valid in the first stall cycle; later cycles carry junk.
      r_inst_buf  <= i_rdata;
      r_buf_valid <= 1'b1;
    end
  end

  assign o_inst = r_buf_valid ? r_inst_buf : i_rdata;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage LoongArch32 pipeline.
// Pre-IF picks the next PC (sequential +4 or ID redirect) and issues it to an
// always-ready instruction SRAM whose data returns one cycle later. IF holds
// the fetched instruction until ID accepts it, and a redirect (flush) kills
// the wrong-path instruction in the same cycle.
//   clk, reset      : clock, synchronous active-high reset
//   if_ready        : IF holds a valid, non-killed instruction for ID
//   id_allow_in     : ID can accept this cycle
//   inst_to_id      : fetched instruction
//   pc_to_id        : PC of inst_to_id
//   flush, newpc    : ID redirect request and its target
//   inst_sram_*     : instruction SRAM interface (read-only, we/wdata tied 0)
module if_fetch_stage #(
  parameter int unsigned     PC_W     = cpu_defs::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  // IF -> ID handshake
  output logic            if_ready,
  input  logic            id_allow_in,
  output logic [31:0]     inst_to_id,
  output logic [PC_W-1:0] pc_to_id,
  // ID redirect
  input  logic            flush,
  input  logic [PC_W-1:0] newpc,
  // instruction SRAM
  output logic            inst_sram_en,
  output logic [3:0]      inst_sram_we,
  output logic [PC_W-1:0] inst_sram_addr,
  output logic [31:0]     inst_sram_wdata,
  input  logic [31:0]     inst_sram_rdata
);

  import cpu_defs::*;

  logic [PC_W-1:0]  r_pc;
  logic             r_if_valid;

  logic [PC_W-1:0]  w_nextpc;
  logic             w_if_ready;
  logic             w_hs;
  logic             w_if_allow_in;
  logic             w_issue;
  logic             w_stall;
  logic [31:0]      w_inst;
  if_id_bus_t       w_if_id_bus;

  // ---------------------------------------------------------------------------
  // Pre-IF: next PC selection
  // ---------------------------------------------------------------------------
  assign w_nextpc = flush ? newpc : pc_plus4(r_pc);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // A flush kills the held instruction this cycle, so ID can never latch it.
  assign w_if_ready    = r_if_valid & ~flush & ~reset;
  assign w_hs          = w_if_ready & id_allow_in;
  assign w_if_allow_in = ~r_if_valid | w_hs | flush;
  assign w_issue       = ~reset & w_if_allow_in;
  assign w_stall       = r_if_valid & ~w_hs & ~flush;

  // ---------------------------------------------------------------------------
  // IF state
  // ---------------------------------------------------------------------------
  // Reset value sits one word before RESET_PC so the first +4 fetch lands on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC - PC_W'(4);
      r_if_valid <= 1'b0;
    end else if (w_issue) begin
      r_pc       <= w_nextpc;
      r_if_valid <= 1'b1;
    end
  end

  if_fetch_stage_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_issue (w_issue),
    .i_stall (w_stall),
    .i_rdata (inst_sram_rdata),
    .o_inst  (w_inst)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_if_id_bus = pack_if_id(r_pc, w_inst);

  assign if_ready   = w_if_ready;
  assign pc_to_id   = w_if_id_bus[IF_ID_BUS_W-1 -: PC_W];
  assign inst_to_id = w_if_id_bus[INST_W-1:0];

  assign inst_sram_en    = w_issue;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wdata = 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_allow_in;
  logic        flush;
  logic [31:0] newpc;
  logic        if_ready;
  logic [31:0] inst_to_id;
  logic [31:0] pc_to_id;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .PC_W     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .if_ready        (if_ready),
    .id_allow_in     (id_allow_in),
    .inst_to_id      (inst_to_id),
    .pc_to_id        (pc_to_id),
    .flush           (flush),
    .newpc           (newpc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  // Address-dependent instruction contents.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_3c3c;
  endfunction

  // Always-ready SRAM: data one cycle after enable, garbage otherwise.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= pat(inst_sram_addr);
    else              inst_sram_rdata <= $urandom();
  end

  // Reference model: does IF own an instruction, and which PC is it.
  // A new fetch starts whenever IF is empty, its instruction is consumed, or
  // ID redirects; the instruction delivered is always the memory word at its PC.
  logic        m_have;
  logic [31:0] m_pc;
  logic        exp_ready;
  logic        exp_en;
  logic [31:0] exp_addr;
  logic [31:0] delivered[$];

  always_comb begin
    exp_ready = m_have && !flush && !reset;
    exp_en    = !reset && (!m_have || flush || (exp_ready && id_allow_in));
    exp_addr  = flush ? newpc : m_pc + 32'd4;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_have <= 1'b0;
      m_pc   <= RST_PC - 32'd4;
    end else if (exp_en) begin
      m_have <= 1'b1;
      m_pc   <= exp_addr;
    end
    if (!reset && if_ready && id_allow_in) delivered.push_back(pc_to_id);
  end

  task automatic drive(input logic r, input logic a, input logic f, input logic [31:0] np);
    @(negedge clk);
    reset       = r;
    id_allow_in = a;
    flush       = f;
    newpc       = np;
    #1;
  endtask

  function automatic int count_delivered(input logic [31:0] pc);
    int c = 0;
    foreach (delivered[i]) if (delivered[i] == pc) c++;
    return c;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(1)), 1'b0, 32'h0);
      n_total++;
      if (if_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", if_ready);
      else n_pass++;
      n_total++;
      if (inst_sram_en !== 1'b0) $display("FAIL reset_en: got %b want 0", inst_sram_en);
      else n_pass++;
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC)
      $display("FAIL first_issue: en=%b addr=%h want en=1 addr=%h", inst_sram_en,
               inst_sram_addr, RST_PC);
    else n_pass++;
    n_total++;
    if (inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'h0)
      $display("FAIL sram_tie: we=%h wdata=%h want 0", inst_sram_we, inst_sram_wdata);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== RST_PC || inst_to_id !== pat(RST_PC))
      $display("FAIL first_fetch: ready=%b pc=%h inst=%h want 1 %h %h", if_ready, pc_to_id,
               inst_to_id, RST_PC, pat(RST_PC));
    else n_pass++;
  endtask

  task automatic test_stream();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== RST_PC + 32'd4 || inst_to_id !== pat(RST_PC + 32'd4))
      $display("FAIL stream: ready=%b pc=%h inst=%h want pc %h", if_ready, pc_to_id, inst_to_id,
               RST_PC + 32'd4);
    else n_pass++;
    n_total++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC + 32'd8)
      $display("FAIL stream_addr: en=%b addr=%h want 1 %h", inst_sram_en, inst_sram_addr,
               RST_PC + 32'd8);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] p;
    p = RST_PC + 32'd8;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (if_ready !== 1'b1 || pc_to_id !== p || inst_to_id !== pat(p) || inst_sram_en !== 1'b0)
        $display("FAIL stall_hold[%0d]: ready=%b pc=%h inst=%h en=%b want 1 %h %h 0", i,
                 if_ready, pc_to_id, inst_to_id, inst_sram_en, p, pat(p));
      else n_pass++;
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (pc_to_id !== p || inst_to_id !== pat(p) || inst_sram_en !== 1'b1 ||
        inst_sram_addr !== p + 32'd4)
      $display("FAIL stall_release: pc=%h inst=%h en=%b addr=%h want %h %h 1 %h", pc_to_id,
               inst_to_id, inst_sram_en, inst_sram_addr, p, pat(p), p + 32'd4);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== p + 32'd4 || inst_to_id !== pat(p + 32'd4))
      $display("FAIL stall_next: ready=%b pc=%h inst=%h want 1 %h", if_ready, pc_to_id,
               inst_to_id, p + 32'd4);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b1, 32'h1c00_0100);
    n_total++;
    if (if_ready !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0100)
      $display("FAIL flush_cycle: ready=%b en=%b addr=%h want 0 1 1c000100", if_ready,
               inst_sram_en, inst_sram_addr);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== 32'h1c00_0100 || inst_to_id !== pat(32'h1c00_0100))
      $display("FAIL flush_target: ready=%b pc=%h inst=%h want 1 1c000100", if_ready, pc_to_id,
               inst_to_id);
    else n_pass++;
    n_total++;
    if (count_delivered(32'h1c00_0010) !== 0)
      $display("FAIL flush_killed: deliveries of 1c000010=%0d want 0",
               count_delivered(32'h1c00_0010));
    else n_pass++;
  endtask

  task automatic test_flush_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h1c00_0200);
      n_total++;
      if (if_ready !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0200)
        $display("FAIL flush_hold[%0d]: ready=%b en=%b addr=%h want 0 1 1c000200", i, if_ready,
                 inst_sram_en, inst_sram_addr);
      else n_pass++;
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== 32'h1c00_0200 || inst_to_id !== pat(32'h1c00_0200))
      $display("FAIL flush_hold_target: ready=%b pc=%h inst=%h want 1 1c000200", if_ready,
               pc_to_id, inst_to_id);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== 32'h1c00_0204)
      $display("FAIL flush_hold_next: ready=%b pc=%h want 1 1c000204", if_ready, pc_to_id);
    else n_pass++;
    n_total++;
    if (count_delivered(32'h1c00_0200) !== 1)
      $display("FAIL flush_hold_once: deliveries of 1c000200=%0d want 1",
               count_delivered(32'h1c00_0200));
    else n_pass++;
  endtask

  task automatic test_flush_in_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      n_total++;
      if (pc_to_id !== 32'h1c00_0208 || inst_to_id !== pat(32'h1c00_0208))
        $display("FAIL fis_stall[%0d]: pc=%h inst=%h want 1c000208 %h", i, pc_to_id, inst_to_id,
                 pat(32'h1c00_0208));
      else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b1, 32'h1c00_0300);
    n_total++;
    if (if_ready !== 1'b0 || inst_sram_addr !== 32'h1c00_0300)
      $display("FAIL fis_flush: ready=%b addr=%h want 0 1c000300", if_ready, inst_sram_addr);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== 32'h1c00_0300 || inst_to_id !== pat(32'h1c00_0300))
      $display("FAIL fis_target: ready=%b pc=%h inst=%h want 1 1c000300 %h", if_ready, pc_to_id,
               inst_to_id, pat(32'h1c00_0300));
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b1, 32'hffff_fffc);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (pc_to_id !== 32'hffff_fffc || inst_sram_addr !== 32'h0)
      $display("FAIL wrap_addr: pc=%h addr=%h want fffffffc 00000000", pc_to_id, inst_sram_addr);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== 32'h0 || inst_to_id !== pat(32'h0))
      $display("FAIL wrap_fetch: ready=%b pc=%h inst=%h want 1 0 %h", if_ready, pc_to_id,
               inst_to_id, pat(32'h0));
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      n_total++;
      if (if_ready !== 1'b0 || inst_sram_en !== 1'b0)
        $display("FAIL rms_reset[%0d]: ready=%b en=%b want 0 0", i, if_ready, inst_sram_en);
      else n_pass++;
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== RST_PC)
      $display("FAIL rms_issue: en=%b addr=%h want 1 %h", inst_sram_en, inst_sram_addr, RST_PC);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_total++;
    if (if_ready !== 1'b1 || pc_to_id !== RST_PC || inst_to_id !== pat(RST_PC))
      $display("FAIL rms_fetch: ready=%b pc=%h inst=%h want 1 %h", if_ready, pc_to_id,
               inst_to_id, RST_PC);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        r, a, f;
    logic [31:0] np;
    int          errs = 0;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) < 2);
      a  = ($urandom_range(99) < 65);
      f  = ($urandom_range(99) < 12);
      np = ($urandom_range(9) == 0) ? 32'hffff_fffc : ($urandom() & 32'hffff_fffc);
      drive(r, a, f, np);
      n_total++;
      if (if_ready !== exp_ready || inst_sram_en !== exp_en) begin
        if (errs < 10)
          $display("FAIL rand_ctrl[%0d]: ready=%b en=%b want %b %b", i, if_ready, inst_sram_en,
                   exp_ready, exp_en);
        errs++;
      end else n_pass++;
      if (exp_en) begin
        n_total++;
        if (inst_sram_addr !== exp_addr) begin
          if (errs < 10)
            $display("FAIL rand_addr[%0d]: addr=%h want %h", i, inst_sram_addr, exp_addr);
          errs++;
        end else n_pass++;
      end
      if (exp_ready) begin
        n_total++;
        if (pc_to_id !== m_pc || inst_to_id !== pat(m_pc)) begin
          if (errs < 10)
            $display("FAIL rand_data[%0d]: pc=%h inst=%h want %h %h", i, pc_to_id, inst_to_id,
                     m_pc, pat(m_pc));
          errs++;
        end else n_pass++;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    id_allow_in = 1'b0;
    flush       = 1'b0;
    newpc       = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_hold();
    test_flush_in_stall();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
